// File: rtl/flags_pkg.sv
// Shared definitions for the condition-flag pipeline: flag bit positions and
// the in-flight entry layout at the default flag count.
package flags_pkg;

    localparam int NFLAGS_DEF = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic                  valid;
        logic [NFLAGS_DEF-1:0] mask;
        logic [NFLAGS_DEF-1:0] flags;
    } flag_entry_t;

endpackage

// File: rtl/flag_stage.sv
// One in-flight flag entry register. Clear wins over load so a flush empties
// the stage even on a cycle that would otherwise shift.
module flag_stage
    import flags_pkg::*;
#(
    parameter type entry_t = flag_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   clear,
    input  entry_t d,
    output entry_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/flag_pipe_unit.sv
// Condition-flag unit: shifts masked flag updates through DEPTH stages, commits
// the oldest into the architectural flags, and forwards the youngest writer per bit.
module flag_pipe_unit
    import flags_pkg::*;
#(
    parameter int NFLAGS = NFLAGS_DEF,
    parameter int DEPTH  = 2,
    parameter bit FWD_EX = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_setflags,
    input  logic [NFLAGS-1:0] ex_mask,
    input  logic [NFLAGS-1:0] ex_flags,
    input  logic              stall,
    input  logic              flush,
    output logic [NFLAGS-1:0] arch_flags,
    output logic [NFLAGS-1:0] fwd_flags,
    output logic              pending
);

    typedef struct packed {
        logic              valid;
        logic [NFLAGS-1:0] mask;
        logic [NFLAGS-1:0] flags;
    } entry_t;

    logic   req;
    logic   advance;
    logic   commit;
    entry_t ex_entry;
    entry_t stg [DEPTH];

    assign req     = ex_valid & ex_setflags & (|ex_mask);
    assign advance = ~stall & ~flush;
    // Flush still retires the oldest entry; only the younger work is discarded.
    assign commit  = (advance | flush) & stg[DEPTH-1].valid;

    always_comb begin
        ex_entry       = '0;
        ex_entry.valid = req;
        ex_entry.mask  = req ? ex_mask : '0;
        ex_entry.flags = ex_flags;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        entry_t d;
        if (g == 0) begin : g_head
            assign d = ex_entry;
        end else begin : g_body
            assign d = stg[g-1];
        end
        flag_stage #(.entry_t(entry_t)) u_stage (
            .clk   (clk),
            .reset (reset),
            .load  (advance),
            .clear (flush),
            .d     (d),
            .q     (stg[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            arch_flags <= '0;
        else if (commit)
            arch_flags <= (arch_flags & ~stg[DEPTH-1].mask)
                        | (stg[DEPTH-1].flags & stg[DEPTH-1].mask);
    end

    // Walk oldest to youngest so the youngest masked writer of each bit wins.
    always_comb begin
        fwd_flags = arch_flags;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            for (int b = 0; b < NFLAGS; b++) begin
                if (stg[i].valid && stg[i].mask[b])
                    fwd_flags[b] = stg[i].flags[b];
            end
        end
        for (int b = 0; b < NFLAGS; b++) begin
            if (FWD_EX && req && !flush && ex_mask[b])
                fwd_flags[b] = ex_flags[b];
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            pending = pending | (stg[i].valid & (|stg[i].mask));
    end

endmodule

// File: tb/tb_flag_pipe_unit.sv
// Directed bench for flag_pipe_unit at NFLAGS=4, DEPTH=2, FWD_EX=1.
module tb_flag_pipe_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid, ex_setflags, stall, flush;
    logic [3:0] ex_mask, ex_flags;
    logic [3:0] arch_flags, fwd_flags;
    logic       pending;

    int n_cmp = 0;
    int n_bad = 0;

    flag_pipe_unit #(.NFLAGS(4), .DEPTH(2), .FWD_EX(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_setflags (ex_setflags),
        .ex_mask     (ex_mask),
        .ex_flags    (ex_flags),
        .stall       (stall),
        .flush       (flush),
        .arch_flags  (arch_flags),
        .fwd_flags   (fwd_flags),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic v, input logic s, input logic [3:0] m, input logic [3:0] f);
        ex_valid = v; ex_setflags = s; ex_mask = m; ex_flags = f;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        ex(0, 0, 4'h0, 4'h0);
        #3;
        chk("rst_arch", arch_flags, 4'h0);
        chk("rst_fwd", fwd_flags, 4'h0);
        chk("rst_pend", pending, 1'b0);
        reset = 1'b1;
        tick();

        // Basic commit: visible on fwd immediately, in arch after 3 edges.
        ex(1, 1, 4'hF, 4'b1010);
        #1;
        chk("basic_fwd_ex", fwd_flags, 4'b1010);
        chk("basic_pend0", pending, 1'b0);
        tick();
        ex(0, 0, 4'h0, 4'h0);
        #1;
        chk("basic_pend1", pending, 1'b1);
        chk("basic_fwd_s0", fwd_flags, 4'b1010);
        tick();
        chk("basic_arch_e2", arch_flags, 4'h0);
        tick();
        chk("basic_arch_e3", arch_flags, 4'b1010);
        chk("basic_pend_done", pending, 1'b0);

        // Masked merge of two partial writers.
        pulse_reset();
        tick();
        ex(1, 1, 4'b1100, 4'hF);
        tick();
        ex(1, 1, 4'b0110, 4'h0);
        #1;
        chk("merge_fwd_ex", fwd_flags, 4'b1000);
        tick();
        ex(0, 0, 4'h0, 4'h0);
        #1;
        chk("merge_fwd_stg", fwd_flags, 4'b1000);
        chk("merge_pend", pending, 1'b1);
        tick();
        chk("merge_arch_a", arch_flags, 4'b1100);
        chk("merge_fwd_mid", fwd_flags, 4'b1000);
        tick();
        chk("merge_arch_b", arch_flags, 4'b1000);
        chk("merge_pend_done", pending, 1'b0);

        // Stall holds the pipe for three edges.
        pulse_reset();
        tick();
        ex(1, 1, 4'hF, 4'h5);
        tick();
        ex(0, 0, 4'h0, 4'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_arch", arch_flags, 4'h0);
            chk("stall_pend", pending, 1'b1);
            chk("stall_fwd", fwd_flags, 4'h5);
        end
        stall = 1'b0;
        tick();
        chk("stall_arch_r1", arch_flags, 4'h0);
        tick();
        chk("stall_arch_r2", arch_flags, 4'h5);

        // Flush under stall: oldest commits, younger entry and EX are dropped.
        pulse_reset();
        tick();
        ex(1, 1, 4'hF, 4'h2);
        tick();
        ex(1, 1, 4'hF, 4'h1);
        tick();
        ex(1, 1, 4'hF, 4'h4);
        flush = 1'b1; stall = 1'b1;
        #1;
        chk("flush_fwd_noex", fwd_flags, 4'h1);
        tick();
        ex(0, 0, 4'h0, 4'h0);
        flush = 1'b0; stall = 1'b0;
        #1;
        chk("flush_arch", arch_flags, 4'h2);
        chk("flush_pend", pending, 1'b0);
        chk("flush_fwd", fwd_flags, 4'h2);
        tick();
        chk("flush_arch_hold", arch_flags, 4'h2);

        // Requests that must not be captured.
        ex(1, 0, 4'hF, 4'hD);
        #1;
        chk("nos_fwd", fwd_flags, 4'h2);
        tick();
        ex(1, 1, 4'h0, 4'hD);
        #1;
        chk("nos_pend", pending, 1'b0);
        chk("nom_fwd", fwd_flags, 4'h2);
        tick();
        ex(0, 1, 4'hF, 4'hD);
        #1;
        chk("nom_pend", pending, 1'b0);
        chk("nov_fwd", fwd_flags, 4'h2);
        tick();
        ex(0, 0, 4'h0, 4'h0);
        tick();
        chk("nocap_pend", pending, 1'b0);
        chk("nocap_arch", arch_flags, 4'h2);

        // Asynchronous reset with two entries in flight.
        ex(1, 1, 4'hF, 4'h9);
        tick();
        ex(1, 1, 4'hF, 4'h6);
        tick();
        ex(0, 0, 4'h0, 4'h0);
        #1;
        chk("mid_pend_pre", pending, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_arch", arch_flags, 4'h0);
        chk("mid_rst_pend", pending, 1'b0);
        chk("mid_rst_fwd", fwd_flags, 4'h0);
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
